// File: rtl/lfo_delay_line.sv
// Modulated stereo delay line (chorus/flanger core) between I2S receiver and transmitter.
// A triangle LFO sweeps the read tap of per-channel circular buffers; outputs are a 50/50 dry/wet mix.
module lfo_delay_line #(
  parameter int WIDTH          = 16,
  parameter int DEPTH_LOG2     = 9,
  parameter int BASE_DELAY     = 64,
  parameter int LFO_DEPTH_LOG2 = 8,
  parameter int LFO_STEP       = 1
) (
  input  logic             sclk,
  input  logic             rst_n,
  input  logic             ws,
  input  logic             bypass,
  input  logic [WIDTH-1:0] left_in,
  input  logic [WIDTH-1:0] right_in,
  output logic [WIDTH-1:0] left_out,
  output logic [WIDTH-1:0] right_out
);

  localparam int AW      = DEPTH_LOG2;
  localparam int LW      = LFO_DEPTH_LOG2;
  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int LFO_MAX = (1 << LFO_DEPTH_LOG2) - 1;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    MIX
  } state_t;

  state_t state_q, state_d;

  logic ws_q;
  logic start_q;
  logic frame_start;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_addr_q, rd_addr_d;
  logic [LW-1:0]    lfo_q, lfo_d;
  logic             dir_q, dir_d;
  logic [AW:0]      prime_q, prime_d;
  logic [WIDTH-1:0] dry_l_q, dry_l_d;
  logic [WIDTH-1:0] dry_r_q, dry_r_d;
  logic [WIDTH-1:0] wet_l_q, wet_r_q;
  logic [WIDTH-1:0] out_l_q, out_l_d;
  logic [WIDTH-1:0] out_r_q, out_r_d;

  logic [WIDTH-1:0] mem_l [DEPTH];
  logic [WIDTH-1:0] mem_r [DEPTH];

  logic [AW-1:0]    delay;
  logic             primed;
  logic [LW:0]      lfo_up;
  logic [LW-1:0]    lfo_next;
  logic             dir_next;
  logic [WIDTH-1:0] wet_eff_l, wet_eff_r;
  logic [WIDTH-1:0] mix_l, mix_r;

  // Falling ws marks the start of the left slot; the strobe is registered once more
  // so the FSM acts one edge after the edge that first sees ws low.
  assign frame_start = ws_q & ~ws;

  assign delay  = AW'(BASE_DELAY) + AW'(lfo_q);
  assign primed = (prime_q == (AW + 1)'(DEPTH));

  assign wet_eff_l = primed ? wet_l_q : '0;
  assign wet_eff_r = primed ? wet_r_q : '0;

  // Halving both terms before the add keeps the sum inside WIDTH bits.
  assign mix_l = ($signed(dry_l_q) >>> 1) + ($signed(wet_eff_l) >>> 1);
  assign mix_r = ($signed(dry_r_q) >>> 1) + ($signed(wet_eff_r) >>> 1);

  assign lfo_up = {1'b0, lfo_q} + (LW + 1)'(LFO_STEP);

  always_comb begin
    lfo_next = lfo_q;
    dir_next = dir_q;
    if (!dir_q) begin
      if (lfo_up >= (LW + 1)'(LFO_MAX)) begin
        lfo_next = LW'(LFO_MAX);
        dir_next = 1'b1;
      end else begin
        lfo_next = lfo_up[LW-1:0];
      end
    end else begin
      if (lfo_q <= LW'(LFO_STEP)) begin
        lfo_next = '0;
        dir_next = 1'b0;
      end else begin
        lfo_next = lfo_q - LW'(LFO_STEP);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_addr_d = rd_addr_q;
    lfo_d     = lfo_q;
    dir_d     = dir_q;
    prime_d   = prime_q;
    dry_l_d   = dry_l_q;
    dry_r_d   = dry_r_q;
    out_l_d   = out_l_q;
    out_r_d   = out_r_q;
    case (state_q)
      IDLE: begin
        if (start_q) begin
          dry_l_d = left_in;
          dry_r_d = right_in;
          state_d = WRITE;
        end
      end
      WRITE: begin
        rd_addr_d = wr_ptr_q - delay;
        state_d   = READ;
      end
      READ: begin
        state_d = MIX;
      end
      MIX: begin
        if (bypass) begin
          out_l_d = dry_l_q;
          out_r_d = dry_r_q;
        end else begin
          out_l_d = mix_l;
          out_r_d = mix_r;
        end
        wr_ptr_d = wr_ptr_q + AW'(1);
        lfo_d    = lfo_next;
        dir_d    = dir_next;
        if (!primed) begin
          prime_d = prime_q + (AW + 1)'(1);
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ws_q      <= 1'b0;
      start_q   <= 1'b0;
      wr_ptr_q  <= '0;
      rd_addr_q <= '0;
      lfo_q     <= '0;
      dir_q     <= 1'b0;
      prime_q   <= '0;
      dry_l_q   <= '0;
      dry_r_q   <= '0;
      wet_l_q   <= '0;
      wet_r_q   <= '0;
      out_l_q   <= '0;
      out_r_q   <= '0;
    end else begin
      state_q   <= state_d;
      ws_q      <= ws;
      start_q   <= frame_start;
      wr_ptr_q  <= wr_ptr_d;
      rd_addr_q <= rd_addr_d;
      lfo_q     <= lfo_d;
      dir_q     <= dir_d;
      prime_q   <= prime_d;
      dry_l_q   <= dry_l_d;
      dry_r_q   <= dry_r_d;
      out_l_q   <= out_l_d;
      out_r_q   <= out_r_d;
      if (state_q == READ) begin
        wet_l_q <= mem_l[rd_addr_q];
        wet_r_q <= mem_r[rd_addr_q];
      end
    end
  end

  // Sample storage is deliberately unreset so it maps onto block RAM.
  always_ff @(posedge sclk) begin
    if (state_q == WRITE) begin
      mem_l[wr_ptr_q] <= dry_l_q;
      mem_r[wr_ptr_q] <= dry_r_q;
    end
  end

  assign left_out  = out_l_q;
  assign right_out = out_r_q;

endmodule

// File: tb/tb_lfo_delay_line.sv
// Directed bench for lfo_delay_line: one static-delay instance (LFO_STEP=0) and one default instance
// share all stimulus; expected outputs come from hand-derived constants and a closed-form triangle model.
module tb_lfo_delay_line;

  logic        sclk    = 1'b0;
  logic        rst_n   = 1'b0;
  logic        ws      = 1'b0;
  logic        bypass  = 1'b0;
  logic [15:0] leftIn  = 16'h0000;
  logic [15:0] rightIn = 16'h0000;
  logic [15:0] sLeftOut, sRightOut;
  logic [15:0] lLeftOut, lRightOut;

  int checks = 0;
  int errors = 0;

  always #5 sclk = ~sclk;

  lfo_delay_line #(.LFO_STEP(0)) dutS (
    .sclk      (sclk),
    .rst_n     (rst_n),
    .ws        (ws),
    .bypass    (bypass),
    .left_in   (leftIn),
    .right_in  (rightIn),
    .left_out  (sLeftOut),
    .right_out (sRightOut)
  );

  lfo_delay_line dutL (
    .sclk      (sclk),
    .rst_n     (rst_n),
    .ws        (ws),
    .bypass    (bypass),
    .left_in   (leftIn),
    .right_in  (rightIn),
    .left_out  (lLeftOut),
    .right_out (lRightOut)
  );

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One 10-cycle frame: ws high 4 cycles, then low; returns 6 negedges after the fall,
  // i.e. after the MIX edge, with outputs settled.
  task automatic applyStimulus(input logic [15:0] l, input logic [15:0] r, input logic bp);
    leftIn  = l;
    rightIn = r;
    bypass  = bp;
    ws      = 1'b1;
    repeat (4) @(negedge sclk);
    ws = 1'b0;
    repeat (6) @(negedge sclk);
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    ws    = 1'b0;
    repeat (3) @(negedge sclk);
    ws    = 1'b1;
    rst_n = 1'b1;
    @(negedge sclk);
  endtask

  function automatic int lfoModel(input int f);
    int p;
    p = f % 510;
    return (p <= 255) ? p : 510 - p;
  endfunction

  initial begin
    logic [15:0] expL;
    logic [15:0] expR;
    int          d;

    $display("[TB] start");

    // Reset held with ws toggling and non-zero inputs
    rst_n   = 1'b0;
    leftIn  = 16'h1234;
    rightIn = 16'h1234;
    bypass  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ws = i[0];
      @(negedge sclk);
    end
    checkOutput("reset_l", lLeftOut, 16'h0000);
    checkOutput("reset_r", lRightOut, 16'h0000);
    checkOutput("reset_s_l", sLeftOut, 16'h0000);
    ws    = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge sclk);
      checkOutput($sformatf("post_reset_l%0d", i), lLeftOut, 16'h0000);
      checkOutput($sformatf("post_reset_r%0d", i), lRightOut, 16'h0000);
    end

    // Reset mid-frame aborts the frame: outputs never pick up the bypassed sample
    repeat (3) @(negedge sclk);
    ws = 1'b0;
    repeat (2) @(negedge sclk);
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ws = i[0];
      @(negedge sclk);
    end
    ws    = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge sclk);
      checkOutput($sformatf("abort_l%0d", i), lLeftOut, 16'h0000);
    end

    // Bypass latency: change lands exactly on edge N+4
    leftIn  = 16'h1234;
    rightIn = 16'hABCD;
    bypass  = 1'b1;
    ws      = 1'b1;
    repeat (4) @(negedge sclk);
    ws = 1'b0;
    repeat (4) @(negedge sclk);
    checkOutput("bypass_pre_l", lLeftOut, 16'h0000);
    checkOutput("bypass_pre_r", lRightOut, 16'h0000);
    @(negedge sclk);
    checkOutput("bypass_n4_l", lLeftOut, 16'h1234);
    checkOutput("bypass_n4_r", lRightOut, 16'hABCD);
    @(negedge sclk);
    leftIn  = 16'h5555;
    rightIn = 16'h6666;
    ws      = 1'b1;
    repeat (4) @(negedge sclk);
    ws = 1'b0;
    repeat (4) @(negedge sclk);
    checkOutput("bypass_hold_l", lLeftOut, 16'h1234);
    checkOutput("bypass_hold_r", lRightOut, 16'hABCD);
    @(negedge sclk);
    checkOutput("bypass_next_l", lLeftOut, 16'h5555);
    checkOutput("bypass_next_r", lRightOut, 16'h6666);
    @(negedge sclk);

    // Pre-prime gating: wet is forced to zero until 512 frames have been written
    resetDut();
    for (int f = 0; f < 514; f++) begin
      applyStimulus(16'h4000, 16'h4000, 1'b0);
      expL = (f < 512) ? 16'h2000 : 16'h4000;
      checkOutput($sformatf("prime_s_l_f%0d", f), sLeftOut, expL);
      checkOutput($sformatf("prime_l_r_f%0d", f), lRightOut, expL);
    end

    // Mix arithmetic on the primed static-delay instance (tap = 64 frames back)
    repeat (64) applyStimulus(16'h7FFF, 16'h7FFF, 1'b0);
    applyStimulus(16'h7FFF, 16'h7FFF, 1'b0);
    checkOutput("mix_7fff_l", sLeftOut, 16'h7FFE);
    checkOutput("mix_7fff_r", sRightOut, 16'h7FFE);
    repeat (64) applyStimulus(16'h8000, 16'h8000, 1'b0);
    applyStimulus(16'h8000, 16'h8000, 1'b0);
    checkOutput("mix_8000_l", sLeftOut, 16'h8000);
    checkOutput("mix_8000_r", sRightOut, 16'h8000);
    repeat (64) applyStimulus(16'hFFFF, 16'hFFFF, 1'b0);
    applyStimulus(16'h0001, 16'h0001, 1'b0);
    checkOutput("mix_0001_ffff_l", sLeftOut, 16'hFFFF);
    checkOutput("mix_0001_ffff_r", sRightOut, 16'hFFFF);

    // Static delay impulse response
    resetDut();
    repeat (512) applyStimulus(16'h0000, 16'h0000, 1'b0);
    applyStimulus(16'h4000, 16'h0000, 1'b0);
    checkOutput("impulse_k_l", sLeftOut, 16'h2000);
    checkOutput("impulse_k_r", sRightOut, 16'h0000);
    for (int j = 1; j < 64; j++) begin
      applyStimulus(16'h0000, 16'h0000, 1'b0);
      checkOutput($sformatf("impulse_k%0d_l", j), sLeftOut, 16'h0000);
      checkOutput($sformatf("impulse_k%0d_r", j), sRightOut, 16'h0000);
    end
    applyStimulus(16'h0000, 16'h0000, 1'b0);
    checkOutput("impulse_k64_l", sLeftOut, 16'h2000);
    checkOutput("impulse_k64_r", sRightOut, 16'h0000);
    applyStimulus(16'h0000, 16'h0000, 1'b0);
    checkOutput("impulse_k65_l", sLeftOut, 16'h0000);

    // LFO sweep: sample value 2f tags frame f, so the wet term reveals the tap position.
    // Bypass for the first 512 frames must not hold back writing, LFO or priming.
    resetDut();
    for (int f = 0; f < 1031; f++) begin
      applyStimulus(16'(2 * f), 16'(2 * f + 4096), (f < 512) ? 1'b1 : 1'b0);
      if (f < 512) begin
        expL = 16'(2 * f);
        expR = 16'(2 * f + 4096);
      end else begin
        d    = 64 + lfoModel(f);
        expL = 16'(2 * f - d);
        expR = 16'(2 * f - d + 4096);
      end
      checkOutput($sformatf("lfo_l_f%0d", f), lLeftOut, expL);
      checkOutput($sformatf("lfo_r_f%0d", f), lRightOut, expR);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
